sobel_window_gen: RTL and testbench

Upstream feeder for the Sobel core. Accepts a raster-order 8-bit pixel stream and buffers the two previous image lines. On each accepted pixel it outputs a registered 3x3 neighbourhood on the nine data ports, plus an enable pulse that drives the core's core_en_i directly. Only interior windows are flagged valid, so the core never sees a window that crosses the image border.

---
 rtl/sobel_window_gen.sv | 131 +++++++++++++
 tb/tb_sobel_window_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/sobel_window_gen.sv
// Raster pixel stream -> registered 3x3 window plus core_en_o for interior windows; 1 clk accept->window.
// No backpressure: every pixel_valid_i beat is consumed. Optional FRAME_DONE_EN adds frame_done_o.
module sobel_window_gen #(
  parameter int PIX_W      = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PIX_W-1:0]              pixel_i,
  input  logic                          pixel_valid_i,
  input  logic                          sof_i,
  output logic [PIX_W-1:0]              data_0_0_o,
  output logic [PIX_W-1:0]              data_0_1_o,
  output logic [PIX_W-1:0]              data_0_2_o,
  output logic [PIX_W-1:0]              data_1_0_o,
  output logic [PIX_W-1:0]              data_1_1_o,
  output logic [PIX_W-1:0]              data_1_2_o,
  output logic [PIX_W-1:0]              data_2_0_o,
  output logic [PIX_W-1:0]              data_2_1_o,
  output logic [PIX_W-1:0]              data_2_2_o,
  output logic                          core_en_o,
  output logic [$clog2(IMG_HEIGHT)-1:0] row_o
`ifdef FRAME_DONE_EN
  ,
  output logic                          frame_done_o
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]    col_q, col_d, pos_c;
  logic [RW-1:0]    row_q, row_d, pos_r;
  logic             core_en_q, core_en_d;
  logic [PIX_W-1:0] win_q [3][3];
  logic [PIX_W-1:0] lb1_q [IMG_WIDTH];
  logic [PIX_W-1:0] lb0_q [IMG_WIDTH];
  logic [PIX_W-1:0] lb1_tap, lb0_tap;

  assign lb1_tap = lb1_q[IMG_WIDTH-1];
  assign lb0_tap = lb0_q[IMG_WIDTH-1];

  // sof_i overrides the counters so a mid-frame sof resynchronises on the same beat.
  always_comb begin
    pos_r     = sof_i ? '0 : row_q;
    pos_c     = sof_i ? '0 : col_q;
    col_d     = col_q;
    row_d     = row_q;
    core_en_d = 1'b0;
    if (pixel_valid_i) begin
      if (pos_c == COL_LAST) begin
        col_d = '0;
        row_d = (pos_r == ROW_LAST) ? '0 : pos_r + RW'(1);
      end else begin
        col_d = pos_c + CW'(1);
        row_d = pos_r;
      end
      core_en_d = (pos_r >= RW'(2)) && (pos_c >= CW'(2));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q     <= '0;
      row_q     <= '0;
      core_en_q <= 1'b0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q     <= col_d;
      row_q     <= row_d;
      core_en_q <= core_en_d;
      if (pixel_valid_i) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb0_tap;
        win_q[1][2] <= lb1_tap;
        win_q[2][2] <= pixel_i;
      end
    end
  end

  // Line storage carries no reset; stale contents only reach windows that are never flagged.
  always_ff @(posedge clk) begin
    if (pixel_valid_i) begin
      lb1_q[0] <= pixel_i;
      lb0_q[0] <= lb1_tap;
      for (int i = 1; i < IMG_WIDTH; i++) begin
        lb1_q[i] <= lb1_q[i-1];
        lb0_q[i] <= lb0_q[i-1];
      end
    end
  end

`ifdef FRAME_DONE_EN
  logic frame_done_q, frame_done_d;

  assign frame_done_d = pixel_valid_i && (pos_r == ROW_LAST) && (pos_c == COL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done_o = frame_done_q;
`endif

  assign data_0_0_o = win_q[0][0];
  assign data_0_1_o = win_q[0][1];
  assign data_0_2_o = win_q[0][2];
  assign data_1_0_o = win_q[1][0];
  assign data_1_1_o = win_q[1][1];
  assign data_1_2_o = win_q[1][2];
  assign data_2_0_o = win_q[2][0];
  assign data_2_1_o = win_q[2][1];
  assign data_2_2_o = win_q[2][2];
  assign core_en_o  = core_en_q;
  assign row_o      = row_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 5x4 image; pixel value = base + 10*r + c.
module tb_sobel_window_gen;
  localparam int PW = 8;
  localparam int W  = 5;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [PW-1:0] pixel_i = '0;
  logic          pixel_valid_i = 1'b0;
  logic          sof_i = 1'b0;
  logic [PW-1:0] d00, d01, d02, d10, d11, d12, d20, d21, d22;
  logic          core_en_o;
  logic [1:0]    row_o;
`ifdef FRAME_DONE_EN
  logic          frame_done_o;
  int            done_cnt = 0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;
  int last_d22 = -1;

  always #5 clk = ~clk;

  sobel_window_gen #(.PIX_W(PW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .pixel_i(pixel_i), .pixel_valid_i(pixel_valid_i), .sof_i(sof_i),
    .data_0_0_o(d00), .data_0_1_o(d01), .data_0_2_o(d02),
    .data_1_0_o(d10), .data_1_1_o(d11), .data_1_2_o(d12),
    .data_2_0_o(d20), .data_2_1_o(d21), .data_2_2_o(d22),
    .core_en_o(core_en_o), .row_o(row_o)
`ifdef FRAME_DONE_EN
    , .frame_done_o(frame_done_o)
`endif
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int win(input int i, input int j);
    case (i * 3 + j)
      0: return int'(d00);
      1: return int'(d01);
      2: return int'(d02);
      3: return int'(d10);
      4: return int'(d11);
      5: return int'(d12);
      6: return int'(d20);
      7: return int'(d21);
      default: return int'(d22);
    endcase
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_en"}, int'(core_en_o), 0);
    check({tag, "_row"}, int'(row_o), 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        check($sformatf("%s_d%0d%0d", tag, i, j), win(i, j), 0);
`ifdef FRAME_DONE_EN
    check({tag, "_done"}, int'(frame_done_o), 0);
`endif
  endtask

  // One clock: drive, clock, sample 1ns after the edge. (r,c) is the position in frame 'base'.
  task automatic step(input int pix, input bit vld, input bit sof, input bit exp_en,
                      input int base, input int r, input int c);
    pixel_i       = PW'(pix);
    pixel_valid_i = vld;
    sof_i         = sof;
    @(posedge clk);
    #1;
    check($sformatf("en@(%0d,%0d)v%0d", r, c, vld), int'(core_en_o), int'(exp_en));
    if (exp_en) begin
      pulses++;
      last_d22 = int'(d22);
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          check($sformatf("win%0d%0d@(%0d,%0d)", i, j, r, c), win(i, j),
                base + 10 * (r - 2 + i) + (c - 2 + j));
    end
`ifdef FRAME_DONE_EN
    check($sformatf("done@(%0d,%0d)v%0d", r, c, vld), int'(frame_done_o),
          int'(exp_en && r == H - 1 && c == W - 1));
    if (frame_done_o) done_cnt++;
`endif
  endtask

  task automatic frame(input int base, input bit sof_first, input bit toggle, input int n_pix);
    for (int k = 0; k < n_pix; k++) begin
      int r = k / W;
      int c = k % W;
      step(base + 10 * r + c, 1'b1, sof_first && k == 0, r >= 2 && c >= 2, base, r, c);
      if (toggle) begin
        step(8'h55, 1'b0, 1'b1, 1'b0, base, r, c);
        check($sformatf("hold_d22@(%0d,%0d)", r, c), int'(d22), base + 10 * r + c);
      end
    end
  endtask

  initial begin
    #12;
    check_zero("reset");
    #6 rst_n = 1'b1;

    // continuous frame
    pulses = 0;
    frame(0, 1'b1, 1'b0, W * H);
    check("s1_pulses", pulses, 6);
    check("s1_last_d22", last_d22, 34);
    check("s1_row_wrap", int'(row_o), 0);

    // valid toggled every cycle
    pulses = 0;
    frame(0, 1'b1, 1'b1, W * H);
    check("s2_pulses", pulses, 6);

`ifdef FRAME_DONE_EN
    done_cnt = 0;
`endif
    // back-to-back frames
    pulses = 0;
    frame(0, 1'b1, 1'b0, W * H);
    frame(100, 1'b1, 1'b0, W * H);
    check("s3_pulses", pulses, 12);
`ifdef FRAME_DONE_EN
    check("s3_done_cnt", done_cnt, 2);
`endif

    // sof at (2,3): partial frame up to (2,2), then new frame starts on that slot
    frame(0, 1'b1, 1'b0, 13);
    pulses = 0;
    frame(200, 1'b1, 1'b0, W * H);
    check("s4_pulses", pulses, 6);

    // asynchronous reset mid-frame, then restart without sof
    frame(0, 1'b1, 1'b0, 14);
    check("s5_row_pre", int'(row_o), 2);
    check("s5_en_pre", int'(core_en_o), 1);
    #3 rst_n = 1'b0;
    #1;
    check_zero("midrst");
    #2 rst_n = 1'b1;
    pulses = 0;
    frame(0, 1'b0, 1'b0, W * H);
    check("s5_pulses", pulses, 6);
    check("s5_last_d22", last_d22, 34);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
